// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_pkg
//  Brief    : Shared types and default sizes for the instruction fetch stage.
//             Optional feature macro used by the fetch stage: IFETCH_BYPASS_EN
//  Revision : 1.0  initial release
// ============================================================================
package ifetch_pkg;

    // Default sizing of the fetch datapath
    localparam int PC_W_DEF     = 12;
    localparam int INSTR_W_DEF  = 19;
    localparam int RESET_PC_DEF = 0;

    // Fetch FSM states
    typedef enum logic [1:0] {
        REQ    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pc_counter
//  Brief    : Program counter register with load (redirect) and increment.
//             Load wins over increment; increment wraps at 2^PC_W.
//  Revision : 1.0  initial release
// ============================================================================
module pc_counter
    import ifetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    // PC update: redirect target first, then sequential advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Brief    : Fetch stage feeding the instruction register. Issues req/ack
//             reads at the PC, buffers one returned word and hands it to
//             decode with a load strobe. Handles redirect with squash of an
//             in-flight read, and a halt state.
//             Optional macro IFETCH_BYPASS_EN: forward an acked word straight
//             to the instruction register when decode is ready that cycle.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               dec_ready,
    output logic               ir_ld,
    output logic [INSTR_W-1:0] ir_d,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               halted
);

    state_t             state;
    // REQ is split into an issue cycle (req_pending=0, halt sampled there)
    // and the outstanding phase (req_pending=1, mem_req high until ack).
    logic               req_pending;
    logic               squash;
    // Address of the outstanding request; frozen even if the PC is redirected
    logic [PC_W-1:0]    req_addr;
    logic [PC_W-1:0]    hold_pc;
    logic [INSTR_W-1:0] hold_reg;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    next_fetch_pc;
    logic               hold_ld;
    logic               bypass_ld;

    // Where the next request goes: a same-cycle redirect wins over the PC
    assign next_fetch_pc = redirect ? redirect_pc : pc;

    assign mem_req  = (state == REQ) && req_pending;
    assign mem_addr = mem_req ? req_addr : pc;
    assign halted   = (state == HALTED);

    // Buffered word goes to decode unless a redirect kills it this cycle
    assign hold_ld  = (state == HOLD) && dec_ready && !redirect;

`ifdef IFETCH_BYPASS_EN
    // Acked, non-squashed word forwarded in the same cycle when decode is ready
    assign bypass_ld = mem_req && mem_ack && !squash && !redirect && dec_ready;
    assign ir_d      = bypass_ld ? mem_rdata : hold_reg;
    assign ir_pc     = bypass_ld ? req_addr  : hold_pc;
`else
    assign bypass_ld = 1'b0;
    assign ir_d      = hold_reg;
    assign ir_pc     = hold_pc;
`endif

    assign ir_ld = hold_ld | bypass_ld;

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (ir_ld),
        .load     (redirect),
        .load_val (redirect_pc),
        .pc       (pc)
    );

    // Fetch FSM: request handshake, squash tracking, buffer and halt control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= REQ;
            req_pending <= 1'b0;
            squash      <= 1'b0;
            req_addr    <= PC_W'(RESET_PC);
            hold_pc     <= '0;
            hold_reg    <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (!req_pending) begin
                        // Issue cycle: acks here belong to no request and are ignored
                        if (redirect || !halt) begin
                            req_pending <= 1'b1;
                            req_addr    <= next_fetch_pc;
                        end else begin
                            state <= HALTED;
                        end
                    end else if (mem_ack) begin
                        if (redirect || squash) begin
                            // Stale word dropped; re-issue at once at the live PC
                            squash   <= 1'b0;
                            req_addr <= next_fetch_pc;
                        end else if (bypass_ld) begin
                            req_pending <= 1'b0;
                            if (halt) begin
                                state <= HALTED;
                            end
                        end else begin
                            req_pending <= 1'b0;
                            hold_reg    <= mem_rdata;
                            hold_pc     <= req_addr;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        // Request must run to its ack; mark its data as dead
                        squash <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        state <= REQ;
                    end else if (dec_ready) begin
                        state <= halt ? HALTED : REQ;
                    end
                end
                HALTED: begin
                    if (redirect || !halt) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state       <= REQ;
                    req_pending <= 1'b0;
                    squash      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Brief    : Self-checking bench for instr_fetch with a latency-programmable
//             memory responder and an instruction-stream reference model.
//             Honours IFETCH_BYPASS_EN for timing expectations.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;
`ifdef IFETCH_BYPASS_EN
    localparam int PER_INSTR = 2;
    localparam int ACK_LD_EXP = 6;
`else
    localparam int PER_INSTR = 3;
    localparam int ACK_LD_EXP = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               dec_ready = 1'b0;
    logic               ir_ld;
    logic [INSTR_W-1:0] ir_d;
    logic [PC_W-1:0]    ir_pc;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               halt = 1'b0;
    logic               halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dec_ready(dec_ready),
        .ir_ld(ir_ld), .ir_d(ir_d), .ir_pc(ir_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
    );

    // Instruction memory image and responder
    logic [INSTR_W-1:0] mem [0:4095];
    int                 mem_lat = 1;
    logic               rand_lat = 1'b0;
    int                 lat_cnt = 0;
    logic               ack_auto = 1'b0;
    logic               ack_manual = 1'b0;
    logic [INSTR_W-1:0] rdata_auto = '0;
    logic [INSTR_W-1:0] rdata_manual = '0;

    assign mem_ack   = ack_auto | ack_manual;
    assign mem_rdata = ack_manual ? rdata_manual : rdata_auto;

    // Ack in the mem_lat-th cycle a request is high; junk data otherwise
    always @(posedge clk) begin
        #1;
        ack_auto   = 1'b0;
        rdata_auto = INSTR_W'($urandom);
        if (!rst) begin
            lat_cnt = 0;
        end else if (mem_req) begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt >= mem_lat) begin
                ack_auto   = 1'b1;
                rdata_auto = mem[mem_addr];
                lat_cnt    = 0;
                if (rand_lat) mem_lat = $urandom_range(1, 3);
            end
        end
    end

    // Log of issued request addresses and address-stability violations
    int              cyc = 0;
    logic            req_open = 1'b0;
    logic [PC_W-1:0] open_addr = '0;
    int              unstable = 0;
    logic [PC_W-1:0] req_log [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            req_open = 1'b0;
        end else if (mem_req) begin
            if (!req_open) begin
                req_log.push_back(mem_addr);
                open_addr = mem_addr;
                req_open  = 1'b1;
            end else if (mem_addr !== open_addr) begin
                unstable = unstable + 1;
            end
            if (mem_ack) req_open = 1'b0;
        end
    end

    task automatic cyc_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic sample_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        ack_manual = 1'b0; rand_lat = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        dec_ready = 1'b0; redirect = 1'b0; halt = 1'b0; mem_lat = 2;
        @(posedge clk);
        #2 rst = 1'b0;
        sample_wait();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (ir_ld !== 1'b0) begin errors++; $display("FAIL reset_ir_ld: got %b expected 0", ir_ld); end
        checks++; if (ir_d !== '0) begin errors++; $display("FAIL reset_ir_d: got %h expected 0", ir_d); end
        checks++; if (ir_pc !== '0) begin errors++; $display("FAIL reset_ir_pc: got %h expected 0", ir_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        sample_wait();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL first_req_cycle: got mem_req=%b expected 0", mem_req); end
        cyc_wait(); sample_wait();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected 1/000", mem_req, mem_addr); end
    endtask

    task automatic test_sequential();
        int n = 0;
        int budget = 0;
        int base;
        mem_lat = 2;
        do_reset();
        base = req_log.size();
        dec_ready = 1'b1;
        while (n < 6 && budget < 200) begin
            cyc_wait(); sample_wait(); budget++;
            if (ir_ld) begin
                checks++; if (ir_pc !== PC_W'(n)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", n, ir_pc, PC_W'(n)); end
                checks++; if (ir_d !== mem[n]) begin errors++; $display("FAIL seq_data[%0d]: got %h expected %h", n, ir_d, mem[n]); end
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL seq_timeout: got %0d loads expected 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (req_log.size() <= base + i || req_log[base + i] !== PC_W'(i)) begin
                errors++; $display("FAIL seq_addr[%0d]: log size %0d, expected address %h", i, req_log.size() - base, PC_W'(i));
            end
        end
    endtask

    task automatic test_stall();
        logic got = 1'b0;
        int budget = 0;
        mem_lat = 1;
        do_reset();
        while (!got && budget < 50) begin
            cyc_wait(); sample_wait(); budget++;
            if (mem_ack) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL stall_ack_timeout: got no ack expected one"); end
        for (int i = 0; i < 5; i++) begin
            cyc_wait(); sample_wait();
            checks++; if (ir_ld !== 1'b0) begin errors++; $display("FAIL stall_ir_ld[%0d]: got %b expected 0", i, ir_ld); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_mem_req[%0d]: got %b expected 0", i, mem_req); end
            checks++; if (ir_d !== mem[0]) begin errors++; $display("FAIL stall_ir_d[%0d]: got %h expected %h", i, ir_d, mem[0]); end
        end
        cyc_wait(); dec_ready = 1'b1; sample_wait();
        checks++; if (ir_ld !== 1'b1 || ir_pc !== 12'h000 || ir_d !== mem[0]) begin errors++; $display("FAIL stall_release: got ld=%b pc=%h d=%h expected 1/000/%h", ir_ld, ir_pc, ir_d, mem[0]); end
        cyc_wait(); dec_ready = 1'b0; sample_wait();
        checks++; if (ir_ld !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL stall_single_pulse: got ld=%b req=%b expected 0/0", ir_ld, mem_req); end
        cyc_wait(); sample_wait();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h001) begin errors++; $display("FAIL stall_next_req: got req=%b addr=%h expected 1/001", mem_req, mem_addr); end
    endtask

    task automatic test_redirect_req();
        logic found = 1'b0;
        logic done = 1'b0;
        int budget = 0;
        int base;
        int unst0;
        mem_lat = 3;
        do_reset();
        unst0 = unstable;
        dec_ready = 1'b1;
        while (!found && budget < 100) begin
            cyc_wait(); sample_wait(); budget++;
            if (mem_req && mem_addr == 12'h004) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rreq_find: got no request to 004 expected one"); end
        cyc_wait(); redirect = 1'b1; redirect_pc = 12'h0A0; sample_wait();
        checks++; if (ir_ld !== 1'b0) begin errors++; $display("FAIL rreq_ld_on_redirect: got %b expected 0", ir_ld); end
        cyc_wait(); redirect = 1'b0; base = req_log.size(); sample_wait();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h004) begin errors++; $display("FAIL rreq_addr_held: got req=%b addr=%h expected 1/004", mem_req, mem_addr); end
        budget = 0;
        while (!done && budget < 40) begin
            if (ir_ld) begin
                done = 1'b1;
                checks++; if (ir_pc !== 12'h0A0) begin errors++; $display("FAIL rreq_first_pc: got %h expected 0a0", ir_pc); end
                checks++; if (ir_d !== mem[12'h0A0]) begin errors++; $display("FAIL rreq_first_data: got %h expected %h", ir_d, mem[12'h0A0]); end
            end else begin
                cyc_wait(); sample_wait(); budget++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL rreq_timeout: got no load expected one"); end
        checks++; if (req_log.size() <= base || req_log[base] !== 12'h0A0) begin errors++; $display("FAIL rreq_next_addr: log size %0d expected next address 0a0", req_log.size() - base); end
        checks++; if (unstable != unst0) begin errors++; $display("FAIL rreq_stable: got %0d address changes expected 0", unstable - unst0); end
    endtask

    task automatic test_redirect_hold();
        logic got = 1'b0;
        logic done = 1'b0;
        int budget = 0;
        int base;
        mem_lat = 1;
        do_reset();
        while (!got && budget < 50) begin
            cyc_wait(); sample_wait(); budget++;
            if (mem_ack) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rhold_ack_timeout: got no ack expected one"); end
        cyc_wait(); dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h010; sample_wait();
        checks++; if (ir_ld !== 1'b0) begin errors++; $display("FAIL rhold_ld: got %b expected 0", ir_ld); end
        cyc_wait(); redirect = 1'b0; base = req_log.size();
        budget = 0;
        while (!done && budget < 40) begin
            sample_wait(); budget++;
            if (ir_ld) begin
                done = 1'b1;
                checks++; if (ir_pc !== 12'h010 || ir_d !== mem[12'h010]) begin errors++; $display("FAIL rhold_first: got pc=%h d=%h expected 010/%h", ir_pc, ir_d, mem[12'h010]); end
            end else begin
                cyc_wait();
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL rhold_timeout: got no load expected one"); end
        checks++; if (req_log.size() <= base || req_log[base] !== 12'h010) begin errors++; $display("FAIL rhold_next_addr: log size %0d expected next address 010", req_log.size() - base); end
    endtask

    task automatic test_wrap_halt();
        logic [PC_W-1:0] exp_pc [2];
        int loads = 0;
        int base;
        logic halt_next = 1'b0;
        logic done = 1'b0;
        int budget = 0;
        exp_pc[0] = 12'hFFF; exp_pc[1] = 12'h000;
        mem_lat = 2;
        do_reset();
        base = req_log.size();
        dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'hFFF;
        cyc_wait(); redirect = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sample_wait();
            if (mem_req && mem_addr == 12'h000) halt_next = 1'b1;
            if (ir_ld) begin
                checks++;
                if (loads >= 2) begin errors++; $display("FAIL wrap_extra_load: got load pc=%h expected none", ir_pc); end
                else if (ir_pc !== exp_pc[loads] || ir_d !== mem[exp_pc[loads]]) begin errors++; $display("FAIL wrap_load[%0d]: got pc=%h d=%h expected %h/%h", loads, ir_pc, ir_d, exp_pc[loads], mem[exp_pc[loads]]); end
                loads++;
            end
            cyc_wait();
            if (halt_next) halt = 1'b1;
        end
        checks++; if (loads != 2) begin errors++; $display("FAIL wrap_load_count: got %0d expected 2", loads); end
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL wrap_halted: got halted=%b req=%b expected 1/0", halted, mem_req); end
        checks++; if (req_log.size() != base + 2 || req_log[base] !== 12'hFFF || req_log[base + 1] !== 12'h000) begin errors++; $display("FAIL wrap_addrs: got %0d requests expected fff,000", req_log.size() - base); end
        halt = 1'b0;
        sample_wait();
        cyc_wait(); sample_wait();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wrap_unhalt: got %b expected 0", halted); end
        while (!done && budget < 20) begin
            if (ir_ld) begin
                done = 1'b1;
                checks++; if (ir_pc !== 12'h001 || ir_d !== mem[1]) begin errors++; $display("FAIL wrap_resume: got pc=%h d=%h expected 001/%h", ir_pc, ir_d, mem[1]); end
            end else begin
                cyc_wait(); sample_wait(); budget++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL wrap_resume_timeout: got no load expected one"); end
    endtask

    task automatic test_throughput();
        int n = 0;
        int budget = 0;
        int ack_ld = 0;
        int t [6];
        mem_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        while (n < 6 && budget < 100) begin
            cyc_wait(); sample_wait(); budget++;
            if (ir_ld) begin
                t[n] = cyc;
                if (mem_ack) ack_ld++;
                checks++; if (ir_d !== mem[n]) begin errors++; $display("FAIL tput_data[%0d]: got %h expected %h", n, ir_d, mem[n]); end
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL tput_timeout: got %0d loads expected 6", n); end
        else begin
            checks++; if (t[5] - t[2] != 3 * PER_INSTR) begin errors++; $display("FAIL tput_rate: got %0d cycles for 3 loads expected %0d", t[5] - t[2], 3 * PER_INSTR); end
        end
        checks++; if (ack_ld != ACK_LD_EXP) begin errors++; $display("FAIL tput_same_cycle: got %0d loads with ack expected %0d", ack_ld, ACK_LD_EXP); end
    endtask

    task automatic test_late_ack();
        logic found = 1'b0;
        logic done = 1'b0;
        int budget = 0;
        mem_lat = 5;
        do_reset();
        dec_ready = 1'b1;
        while (!found && budget < 20) begin
            cyc_wait(); sample_wait(); budget++;
            if (mem_req) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL late_find: got no request expected one"); end
        cyc_wait();
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || ir_ld !== 1'b0) begin errors++; $display("FAIL late_async_reset: got req=%b ld=%b expected 0/0", mem_req, ir_ld); end
        repeat (2) cyc_wait();
        rst = 1'b1; ack_manual = 1'b1; rdata_manual = ~mem[0];
        cyc_wait(); ack_manual = 1'b0;
        budget = 0;
        while (!done && budget < 40) begin
            sample_wait(); budget++;
            if (ir_ld) begin
                done = 1'b1;
                checks++; if (ir_pc !== 12'h000 || ir_d !== mem[0]) begin errors++; $display("FAIL late_first_load: got pc=%h d=%h expected 000/%h", ir_pc, ir_d, mem[0]); end
            end else begin
                cyc_wait();
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL late_timeout: got no load expected one"); end
    endtask

    // Stream model: loads follow exp_pc, which steps by one per load and jumps on redirect
    task automatic test_random();
        logic [PC_W-1:0] exp_pc = '0;
        int loads = 0;
        int unst0;
        do_reset();
        unst0 = unstable;
        rand_lat = 1'b1; mem_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            cyc_wait();
            dec_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = PC_W'($urandom);
            sample_wait();
            if (redirect) begin
                checks++; if (ir_ld !== 1'b0) begin errors++; $display("FAIL rand_ld_on_redirect[%0d]: got %b expected 0", i, ir_ld); end
                exp_pc = redirect_pc;
            end else if (ir_ld) begin
                checks++; if (ir_pc !== exp_pc || ir_d !== mem[exp_pc]) begin errors++; $display("FAIL rand_load[%0d]: got pc=%h d=%h expected %h/%h", i, ir_pc, ir_d, exp_pc, mem[exp_pc]); end
                exp_pc = exp_pc + PC_W'(1);
                loads++;
            end
        end
        redirect = 1'b0; rand_lat = 1'b0;
        checks++; if (loads < 150) begin errors++; $display("FAIL rand_progress: got %0d loads expected at least 150", loads); end
        checks++; if (unstable != unst0) begin errors++; $display("FAIL rand_stable: got %0d address changes expected 0", unstable - unst0); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = INSTR_W'($urandom);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_req();
        test_redirect_hold();
        test_wrap_halt();
        test_throughput();
        test_late_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the 19-bit instruction register.
- Holds the PC and issues req/ack reads to instruction memory.
- Buffers one returned instruction word and drives the instruction register's load strobe and data (ir_ld, ir_d) when decode is ready.
- Supports redirect (branch/jump) with squash of an in-flight read, and a halt state.

Parameters:
- PC_W, 12, program counter / instruction address width
- INSTR_W, 19, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- mem_req  output  1  instruction memory read request
- mem_addr  output  PC_W  read address
- mem_ack  input  1  read data valid; one-cycle pulse per request
- mem_rdata  input  INSTR_W  instruction word, valid when mem_ack=1
- dec_ready  input  1  decode can accept a new instruction this cycle
- ir_ld  output  1  load strobe to instruction register (1-cycle pulse)
- ir_d  output  INSTR_W  instruction presented to instruction register
- ir_pc  output  PC_W  address of instruction on ir_d
- redirect  input  1  branch/jump taken
- redirect_pc  input  PC_W  new fetch address
- halt  input  1  level; stop fetching
- halted  output  1  FSM is in HALTED

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=REQ; squash=0.
  - mem_req=0, ir_ld=0, ir_d=0, ir_pc=0, halted=0.
- Outputs are registered except mem_req, mem_addr, ir_ld and halted, which decode from state.
- mem_addr=pc.
- States:
  - REQ:
    - mem_req=1.
    - On mem_ack with squash=0: hold_reg<=mem_rdata, hold_pc<=pc, go HOLD.
    - On mem_ack with squash=1: drop data, clear squash, stay REQ (new request issued the next cycle at the current pc).
  - HOLD:
    - mem_req=0; ir_d=hold_reg; ir_pc=hold_pc.
    - If dec_ready: ir_ld=1 this cycle, pc<=pc+1, go REQ, or go HALTED if halt=1.
  - HALTED:
    - mem_req=0, halted=1.
    - Leave to REQ when halt=0 (pc unchanged), or when redirect=1 (pc<=redirect_pc).
- Handshake rules:
  - mem_req, once raised, stays high with mem_addr stable until mem_ack, even across redirect.
  - Exactly one ack per request.
  - ir_ld never asserts for squashed data.
- Redirect has priority over all other events in the same cycle:
  - pc<=redirect_pc.
  - In REQ without mem_ack: squash<=1. mem_addr stays at the old pc until the ack; the next request uses redirect_pc.
  - In REQ with mem_ack: data dropped, no squash needed, next cycle requests redirect_pc.
  - In HOLD: buffer discarded, ir_ld=0, go REQ.
- Halt:
  - Sampled only in REQ with no outstanding request (mem_req not yet raised, i.e. the first cycle of REQ), and on leaving HOLD.
  - An outstanding request always completes before HALTED.
- PC arithmetic: unsigned PC_W bits; increment wraps 2^PC_W-1 -> 0.
- Latency (without bypass): mem_ack at cycle n -> ir_ld no earlier than cycle n+1.
- Reset mid-transaction: all state cleared immediately. A late mem_ack after reset release with no request outstanding is ignored.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined: in REQ, if mem_ack=1, squash=0, redirect=0 and dec_ready=1 in the same cycle:
  - ir_ld=1 that cycle with ir_d=mem_rdata, ir_pc=pc.
  - pc<=pc+1, stay REQ (or go HALTED if halt=1); HOLD is skipped.
  - ir_d/ir_pc are combinational muxes in this case.
- Not defined: every ack passes through HOLD; ir_d/ir_pc are purely registered.

Decomposition:
- Package ifetch_pkg:
  - state enum {REQ, HOLD, HALTED}
  - default PC_W=12, INSTR_W=19
  - RESET_PC constant
- Sub-module pc_counter:
  - ports: clk, rst, inc, load, load_val, pc
  - async active-low reset to RESET_PC; load has priority over inc.

Test Plan:
1. Reset, memory acks every request after 2 cycles, dec_ready=1 -> mem_addr 0,1,2,…; ir_ld pulses carry the memory words in order with ir_pc=0,1,2.
2. dec_ready=0 for 5 cycles while in HOLD -> ir_ld stays 0, mem_req stays 0, ir_d stable. dec_ready=1 -> single ir_ld pulse, then a request to the next pc.
3. redirect to 0x0A0 while a request to 0x004 is outstanding -> mem_addr stays 0x004 until ack, returned word never loaded, next mem_addr=0x0A0, first ir_pc=0x0A0.
4. redirect to 0x010 in the same cycle as HOLD with dec_ready=1 -> no ir_ld; next request to 0x010.
5. RESET_PC=0xFFF -> fetches at 0xFFF then 0x000 (wrap). halt=1 during the second request -> ack completes, ir_ld once, halted=1. halt=0 -> resumes at 0x001.
6. IFETCH_BYPASS_EN: ack and dec_ready in the same cycle -> ir_ld in that cycle with ir_d=mem_rdata; back-to-back single-cycle-ack memory gives one instruction per 2 cycles. Without the macro: one per 3 cycles.
